// File: rtl/ltpi_io_bridge_pkg.sv
// ltpi_io_bridge_pkg: shared link-state type and counter sizing helper
package ltpi_io_bridge_pkg;
  typedef enum logic [1:0] {DOWN = 2'd0, QUAL = 2'd1, UP = 2'd2, HOLD = 2'd3} link_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ltpi_io_filter.sv
// ltpi_io_filter: two-flop synchroniser followed by a per-bit consecutive-sample glitch filter
module ltpi_io_filter import ltpi_io_bridge_pkg::*; #(
  parameter int W = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  localparam int CW = cnt_w(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
  logic [W-1:0] s1, s2;
  // bring asynchronous pins into the clock domain
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2, s1} <= '0;
    else {s2, s1} <= {s1, d};
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic qb;
    logic [CW-1:0] c;
    // accept a new level only after FILTER_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        c  <= '0;
        qb <= 1'b0;
      end else if (s2[i] == qb) c <= '0;
      else if (c == LAST) begin
        c  <= '0;
        qb <= s2[i];
      end else c <= c + CW'(1);
    assign q[i] = qb;
  end
endmodule

// File: rtl/ltpi_target_io_bridge.sv
// ltpi_target_io_bridge: filtered pin inputs to the LTPI core and link-qualified pin outputs
module ltpi_target_io_bridge import ltpi_io_bridge_pkg::*; #(
  parameter int NL_PINS = 8,
  parameter int LL_PINS = 4,
  parameter int UART_CH = 2,
  parameter int NL_BUS_W = 1024,
  parameter int LL_BUS_W = 16,
  parameter int FILTER_CYCLES = 4,
  parameter int UP_QUAL_CYCLES = 8,
  parameter int DOWN_HOLD_CYCLES = 16,
  parameter logic [NL_PINS-1:0] NL_SAFE = '0,
  parameter logic [LL_PINS-1:0] LL_SAFE = '0
) (
  input  logic                CLK_25M_OSC_CPU_FPGA,
  input  logic                reset_in,
  input  logic                aligned,
  input  logic [NL_PINS-1:0]  nl_pin_in,
  output logic [NL_PINS-1:0]  nl_pin_out,
  input  logic [LL_PINS-1:0]  ll_pin_in,
  output logic [LL_PINS-1:0]  ll_pin_out,
  input  logic [UART_CH-1:0]  uart_rx_pin,
  input  logic [UART_CH-1:0]  uart_cts_pin,
  output logic [UART_CH-1:0]  uart_tx_pin,
  output logic [UART_CH-1:0]  uart_rts_pin,
  output logic [NL_BUS_W-1:0] nl_gpio_in,
  input  logic [NL_BUS_W-1:0] nl_gpio_out,
  output logic [LL_BUS_W-1:0] ll_gpio_in,
  input  logic [LL_BUS_W-1:0] ll_gpio_out,
  output logic [UART_CH-1:0]  uart_rxd,
  output logic [UART_CH-1:0]  uart_cts,
  input  logic [UART_CH-1:0]  uart_txd,
  input  logic [UART_CH-1:0]  uart_rts,
  output logic [1:0]          link_state,
  output logic [7:0]          link_drop_cnt
);
  localparam int FW = cnt_w(UP_QUAL_CYCLES > DOWN_HOLD_CYCLES ? UP_QUAL_CYCLES : DOWN_HOLD_CYCLES);
  localparam logic [FW-1:0] QUAL_LAST = FW'(UP_QUAL_CYCLES - 1);
  localparam logic [FW-1:0] HOLD_LAST = FW'(DOWN_HOLD_CYCLES - 1);
  link_state_t state, state_n;
  logic [FW-1:0] cnt, cnt_n;
  logic [NL_PINS-1:0] nl_filt;
  logic [LL_PINS-1:0] ll_filt;
  logic [UART_CH-1:0] rx_s1, cts_s1;
  logic unused;
  ltpi_io_filter #(.W(NL_PINS), .FILTER_CYCLES(FILTER_CYCLES)) u_nl_filter (
    .clk(CLK_25M_OSC_CPU_FPGA), .rst(reset_in), .d(nl_pin_in), .q(nl_filt));
  ltpi_io_filter #(.W(LL_PINS), .FILTER_CYCLES(FILTER_CYCLES)) u_ll_filter (
    .clk(CLK_25M_OSC_CPU_FPGA), .rst(reset_in), .d(ll_pin_in), .q(ll_filt));
  assign nl_gpio_in = NL_BUS_W'(nl_filt);
  assign ll_gpio_in = LL_BUS_W'(ll_filt);
  assign link_state = state;
  assign unused = ^{nl_gpio_out, ll_gpio_out};
  // UART lines are only synchronised; idle level is high
  always_ff @(posedge CLK_25M_OSC_CPU_FPGA or posedge reset_in)
    if (reset_in) {uart_rxd, rx_s1, uart_cts, cts_s1} <= '1;
    else {uart_rxd, rx_s1, uart_cts, cts_s1} <= {rx_s1, uart_rx_pin, cts_s1, uart_cts_pin};
  // link FSM next state; a change of aligned wins over a counter reaching its terminal value
  always_comb begin
    state_n = state;
    cnt_n = cnt + FW'(1);
    unique case (state)
      DOWN: begin
        cnt_n = '0;
        if (aligned) state_n = QUAL;
      end
      QUAL: if (!aligned) state_n = DOWN;
            else if (cnt == QUAL_LAST) state_n = UP;
      UP: begin
        cnt_n = '0;
        if (!aligned) state_n = HOLD;
      end
      HOLD: if (aligned) begin
              state_n = UP;
              cnt_n = '0;
            end else if (cnt == HOLD_LAST) state_n = DOWN;
    endcase
  end
  // link FSM state, qualification counter and saturating drop counter
  always_ff @(posedge CLK_25M_OSC_CPU_FPGA or posedge reset_in)
    if (reset_in) begin
      state <= DOWN;
      cnt <= '0;
      link_drop_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      link_drop_cnt <= link_drop_cnt + 8'(state == UP && !aligned && link_drop_cnt != 8'hFF);
    end
  // pin outputs follow the core in UP, freeze in HOLD, and drive safe levels otherwise
  always_ff @(posedge CLK_25M_OSC_CPU_FPGA or posedge reset_in)
    if (reset_in) begin
      nl_pin_out <= NL_SAFE;
      ll_pin_out <= LL_SAFE;
      uart_tx_pin <= '1;
      uart_rts_pin <= '1;
    end else if (state == UP) begin
      nl_pin_out <= nl_gpio_out[NL_PINS-1:0];
      ll_pin_out <= ll_gpio_out[LL_PINS-1:0];
      uart_tx_pin <= uart_txd;
      uart_rts_pin <= uart_rts;
    end else if (state != HOLD) begin
      nl_pin_out <= NL_SAFE;
      ll_pin_out <= LL_SAFE;
      uart_tx_pin <= '1;
      uart_rts_pin <= '1;
    end
endmodule

// File: tb/tb_ltpi_target_io_bridge.sv
// tb_ltpi_target_io_bridge: table, directed and randomized model-based checks of the I/O bridge
module tb_ltpi_target_io_bridge;
  localparam int NP = 8, LP = 4, NW = 1024, LW = 16, FC = 4, UQ = 8, DH = 16;
  logic clk = 0, rst = 1, aligned = 0;
  logic [NP-1:0] nl_pin_in = '0, nl_pin_out;
  logic [LP-1:0] ll_pin_in = '0, ll_pin_out;
  logic [1:0] uart_rx_pin = '1, uart_cts_pin = '1, uart_tx_pin, uart_rts_pin;
  logic [NW-1:0] nl_gpio_in, nl_gpio_out = '0;
  logic [LW-1:0] ll_gpio_in, ll_gpio_out = '0;
  logic [1:0] uart_rxd, uart_cts, uart_txd = '0, uart_rts = '0;
  logic [1:0] link_state;
  logic [7:0] link_drop_cnt;
  logic [63:0] d2_nl_pin_in = '0, d2_nl_pin_out;
  logic [LP-1:0] d2_ll_pin_out;
  logic [0:0] d2_tx_pin, d2_rts_pin, d2_rxd, d2_cts;
  logic [NW-1:0] d2_nl_gpio_in;
  logic [LW-1:0] d2_ll_gpio_in;
  logic [1:0] d2_link_state;
  logic [7:0] d2_drop;
  int n_cmp = 0, n_bad = 0;

  ltpi_target_io_bridge dut (
    .CLK_25M_OSC_CPU_FPGA(clk), .reset_in(rst), .aligned(aligned),
    .nl_pin_in(nl_pin_in), .nl_pin_out(nl_pin_out), .ll_pin_in(ll_pin_in), .ll_pin_out(ll_pin_out),
    .uart_rx_pin(uart_rx_pin), .uart_cts_pin(uart_cts_pin), .uart_tx_pin(uart_tx_pin), .uart_rts_pin(uart_rts_pin),
    .nl_gpio_in(nl_gpio_in), .nl_gpio_out(nl_gpio_out), .ll_gpio_in(ll_gpio_in), .ll_gpio_out(ll_gpio_out),
    .uart_rxd(uart_rxd), .uart_cts(uart_cts), .uart_txd(uart_txd), .uart_rts(uart_rts),
    .link_state(link_state), .link_drop_cnt(link_drop_cnt));

  ltpi_target_io_bridge #(.NL_PINS(64), .UART_CH(1), .FILTER_CYCLES(1)) dut2 (
    .CLK_25M_OSC_CPU_FPGA(clk), .reset_in(rst), .aligned(aligned),
    .nl_pin_in(d2_nl_pin_in), .nl_pin_out(d2_nl_pin_out), .ll_pin_in(ll_pin_in), .ll_pin_out(d2_ll_pin_out),
    .uart_rx_pin(1'b1), .uart_cts_pin(1'b1), .uart_tx_pin(d2_tx_pin), .uart_rts_pin(d2_rts_pin),
    .nl_gpio_in(d2_nl_gpio_in), .nl_gpio_out(nl_gpio_out), .ll_gpio_in(d2_ll_gpio_in), .ll_gpio_out(ll_gpio_out),
    .uart_rxd(d2_rxd), .uart_cts(d2_cts), .uart_txd(1'b0), .uart_rts(1'b0),
    .link_state(d2_link_state), .link_drop_cnt(d2_drop));

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_up();
    for (int i = 0; i < 40 && link_state != 2'd2; i++) @(negedge clk);
    chk("wait_up", 64'(link_state), 64'd2);
  endtask

  // behavioural reference: sliding-window filter, two-sample UART delay, link rules
  logic [11:0] m_hist[$];
  logic [11:0] m_q;
  logic [1:0] m_rxd, m_rxp, m_cts, m_ctsp, m_tx, m_rts;
  logic [7:0] m_nl;
  logic [3:0] m_ll;
  int m_state, m_run, m_drop;

  task automatic m_reset();
    m_hist.delete();
    repeat (FC + 2) m_hist.push_back('0);
    m_q = '0; m_rxd = '1; m_rxp = '1; m_cts = '1; m_ctsp = '1;
    m_nl = '0; m_ll = '0; m_tx = '1; m_rts = '1;
    m_state = 0; m_run = 0; m_drop = 0;
  endtask

  task automatic m_step();
    logic [11:0] all1, all0;
    m_hist.push_front({ll_pin_in, nl_pin_in});
    void'(m_hist.pop_back());
    all1 = '1; all0 = '1;
    for (int j = 2; j < FC + 2; j++) begin
      all1 &= m_hist[j];
      all0 &= ~m_hist[j];
    end
    m_q = all1 | (m_q & ~all0);
    m_rxd = m_rxp; m_rxp = uart_rx_pin;
    m_cts = m_ctsp; m_ctsp = uart_cts_pin;
    if (m_state == 2) begin
      m_nl = nl_gpio_out[7:0]; m_ll = ll_gpio_out[3:0]; m_tx = uart_txd; m_rts = uart_rts;
    end else if (m_state != 3) begin
      m_nl = '0; m_ll = '0; m_tx = '1; m_rts = '1;
    end
    case (m_state)
      0: if (aligned) begin m_state = 1; m_run = 0; end
      1: if (!aligned) m_state = 0;
         else if (m_run == UQ - 1) m_state = 2;
         else m_run++;
      2: if (!aligned) begin
           m_state = 3; m_run = 0;
           if (m_drop < 255) m_drop++;
         end
      default: if (aligned) m_state = 2;
               else if (m_run == DH - 1) m_state = 0;
               else m_run++;
    endcase
  endtask

  task automatic m_compare();
    chk("rand_nl_in", nl_gpio_in[63:0], 64'(m_q[7:0]));
    chk("rand_ll_in", 64'(ll_gpio_in), 64'(m_q[11:8]));
    chk("rand_uart_in", 64'({uart_rxd, uart_cts}), 64'({m_rxd, m_cts}));
    chk("rand_pins", 64'({nl_pin_out, ll_pin_out, uart_tx_pin, uart_rts_pin}), 64'({m_nl, m_ll, m_tx, m_rts}));
    chk("rand_link", 64'({link_state, link_drop_cnt}), 64'({2'(m_state), 8'(m_drop)}));
  endtask

  typedef struct {int len; logic seen; int delay;} pulse_t;
  pulse_t tbl[5];

  initial begin
    int q, first;
    logic ok;
    logic [63:0] prev, nv;
    tbl = '{'{3, 1'b0, 0}, '{4, 1'b1, 6}, '{1, 1'b0, 0}, '{7, 1'b1, 6}, '{2, 1'b0, 0}};
    repeat (2) @(negedge clk);
    chk("rst_nl_out", 64'(nl_pin_out), 64'd0);
    chk("rst_uart_out", 64'({uart_tx_pin, uart_rts_pin}), 64'hF);
    chk("rst_core_in", nl_gpio_in[63:0] | 64'(ll_gpio_in), 64'd0);
    chk("rst_uart_in", 64'({uart_rxd, uart_cts}), 64'hF);
    chk("rst_link", 64'({link_state, link_drop_cnt}), 64'd0);
    rst = 0;
    // link bring-up
    nl_gpio_out = NW'(8'hA5);
    aligned = 1;
    q = 0; ok = 1;
    for (int i = 0; i < 40 && link_state != 2'd2; i++) begin
      @(negedge clk);
      if (link_state == 2'd1) q++;
      if (link_state != 2'd2) ok &= (nl_pin_out == '0) && (uart_tx_pin == 2'b11) && (uart_rts_pin == 2'b11);
    end
    chk("qual_cycles", 64'(q), 64'd8);
    chk("up_reached", 64'(link_state), 64'd2);
    chk("safe_before_up", 64'(ok), 64'd1);
    chk("up_first_cycle_lag", 64'(nl_pin_out), 64'd0);
    @(negedge clk);
    chk("up_nl_out", 64'(nl_pin_out), 64'hA5);
    chk("up_uart_out", 64'({uart_tx_pin, uart_rts_pin}), 64'd0);
    // glitch filter table on nl_pin_in[3]
    foreach (tbl[k]) begin
      nl_pin_in[3] = 1'b1;
      first = 0;
      for (int t = 1; t <= 16; t++) begin
        @(negedge clk);
        if (nl_gpio_in[3] && first == 0) first = t;
        if (t == tbl[k].len) nl_pin_in[3] = 1'b0;
      end
      chk("pulse_seen", 64'(first != 0), 64'(tbl[k].seen));
      chk("pulse_delay", 64'(first), 64'(tbl[k].delay));
      chk("pulse_settled", nl_gpio_in[63:0], 64'd0);
    end
    // short drop: HOLD freezes outputs then rejoins UP
    aligned = 0;
    @(negedge clk);
    nl_gpio_out = NW'(8'h3C);
    chk("hold_state", 64'(link_state), 64'd3);
    repeat (3) @(negedge clk);
    chk("hold_frozen", 64'(nl_pin_out), 64'hA5);
    @(negedge clk);
    aligned = 1;
    @(negedge clk);
    chk("rejoin_up", 64'(link_state), 64'd2);
    chk("drop_one", 64'(link_drop_cnt), 64'd1);
    chk("rejoin_lag", 64'(nl_pin_out), 64'hA5);
    @(negedge clk);
    chk("rejoin_track", 64'(nl_pin_out), 64'h3C);
    // long drop: HOLD expires into DOWN
    aligned = 0;
    q = 0;
    for (int i = 0; i < 40 && (i == 0 || link_state != 2'd0); i++) begin
      @(negedge clk);
      if (link_state == 2'd3) q++;
    end
    chk("hold_cycles", 64'(q), 64'd16);
    chk("down_state", 64'(link_state), 64'd0);
    chk("down_lag", 64'(nl_pin_out), 64'h3C);
    @(negedge clk);
    chk("down_safe", 64'({nl_pin_out, uart_tx_pin, uart_rts_pin}), 64'h00F);
    chk("drop_two", 64'(link_drop_cnt), 64'd2);
    // saturation of drop counter
    aligned = 1;
    wait_up();
    for (int i = 0; i < 300; i++) begin
      aligned = 0;
      @(negedge clk);
      aligned = 1;
      @(negedge clk);
      if (i == 99) chk("drop_102", 64'(link_drop_cnt), 64'd102);
    end
    chk("drop_saturated", 64'(link_drop_cnt), 64'd255);
    // asynchronous reset mid-UP
    nl_gpio_out = NW'(8'hA5);
    nl_pin_in = 8'hFF;
    uart_rx_pin = 2'b00;
    repeat (8) @(negedge clk);
    chk("pre_rst_in", 64'({nl_gpio_in[7:0], uart_rxd}), 64'h3FC);
    chk("pre_rst_out", 64'(nl_pin_out), 64'hA5);
    #5 rst = 1;
    #1;
    chk("arst_pins", 64'({nl_pin_out, uart_tx_pin, uart_rts_pin}), 64'h00F);
    chk("arst_link", 64'({link_state, link_drop_cnt}), 64'd0);
    chk("arst_core_in", 64'({nl_gpio_in[7:0], uart_rxd}), 64'h003);
    @(negedge clk);
    rst = 0;
    aligned = 0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (t == 5) chk("refilter_5", 64'(nl_gpio_in[7:0]), 64'd0);
      if (t == 6) chk("refilter_6", 64'(nl_gpio_in[7:0]), 64'hFF);
    end
    // wide variant with a one-sample filter
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      nv = prev ^ ({$urandom(), $urandom()} | 64'h1);
      d2_nl_pin_in = nv;
      repeat (2) @(negedge clk);
      chk("d2_lat2", d2_nl_gpio_in[63:0], prev);
      @(negedge clk);
      chk("d2_lat3", d2_nl_gpio_in[63:0], nv);
      chk("d2_upper_zero", 64'(|d2_nl_gpio_in[NW-1:64]), 64'd0);
      prev = nv;
    end
    // randomized run against the reference model
    nl_pin_in = '0; ll_pin_in = '0; uart_rx_pin = '1; uart_cts_pin = '1; aligned = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_reset();
    m_compare();
    for (int c = 0; c < 1500; c++) begin
      for (int j = 0; j < NP; j++) if ($urandom_range(5) == 0) nl_pin_in[j] = ~nl_pin_in[j];
      for (int j = 0; j < LP; j++) if ($urandom_range(3) == 0) ll_pin_in[j] = ~ll_pin_in[j];
      if ($urandom_range(11) == 0) aligned = ~aligned;
      uart_rx_pin = 2'($urandom());
      uart_cts_pin = 2'($urandom());
      nl_gpio_out = NW'({$urandom(), $urandom()});
      ll_gpio_out = LW'($urandom());
      uart_txd = 2'($urandom());
      uart_rts = 2'($urandom());
      m_step();
      @(negedge clk);
      m_compare();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ltpi_target_io_bridge.md
Name: ltpi_target_io_bridge

Overview:
- Parametrised pin-side bridge between target-board physical I/O and the LTPI target core tunnel buses (nl_gpio, ll_gpio, uart).
- Generalises the fixed one-pin wiring to N pins per class and N UART channels.
- Inputs are synchronised and glitch-filtered; outputs are gated by a link-qualification FSM so pins drive safe values while the link is not aligned.
- Sits between board top level and ltpi_top_target.

Parameters:
- NL_PINS, 8, physical normal-latency GPIO pins (1..64)
- LL_PINS, 4, physical low-latency GPIO pins (1..16)
- UART_CH, 2, UART channels (1..2)
- NL_BUS_W, 1024, width of core nl_gpio buses
- LL_BUS_W, 16, width of core ll_gpio buses
- FILTER_CYCLES, 4, consecutive equal samples needed to accept a GPIO input change (>=1)
- UP_QUAL_CYCLES, 8, cycles aligned must stay high before pass-through
- DOWN_HOLD_CYCLES, 16, cycles outputs freeze after aligned drops before going safe
- NL_SAFE, all-0 [NL_PINS], NL pin value when link down
- LL_SAFE, all-0 [LL_PINS], LL pin value when link down

Ports:
- CLK_25M_OSC_CPU_FPGA in 1: single clock for all logic
- reset_in in 1: asynchronous, active-high reset
- aligned in 1: link aligned from core (core clock domain = this clock)
- nl_pin_in in NL_PINS: physical NL GPIO inputs (async)
- nl_pin_out out NL_PINS: physical NL GPIO outputs
- ll_pin_in in LL_PINS: physical LL GPIO inputs (async)
- ll_pin_out out LL_PINS: physical LL GPIO outputs
- uart_rx_pin in UART_CH: physical RXD (async)
- uart_cts_pin in UART_CH: physical CTS (async)
- uart_tx_pin out UART_CH: physical TXD
- uart_rts_pin out UART_CH: physical RTS
- nl_gpio_in out NL_BUS_W: to core; bits [NL_PINS-1:0] filtered pins, rest 0
- nl_gpio_out in NL_BUS_W: from core; bits [NL_PINS-1:0] used
- ll_gpio_in out LL_BUS_W: to core; same mapping
- ll_gpio_out in LL_BUS_W: from core
- uart_rxd out UART_CH, uart_cts out UART_CH: to core
- uart_txd in UART_CH, uart_rts in UART_CH: from core
- link_state out 2: FSM state encoding
- link_drop_cnt out 8: saturating count of UP->HOLD transitions

Behaviour:
- Input path, GPIO:
  - Every pin passes through a 2-flop synchroniser, then a per-bit filter counter.
  - A filtered bit changes only after FILTER_CYCLES consecutive synced samples differ from the current filtered value; the counter clears on any sample equal to the filtered value.
  - Latency pin to core is 2 + FILTER_CYCLES cycles. Reset value of filtered bits is 0.
- Input path, UART: rx and cts are 2-flop synchronised only, with no filter (latency 2). Synchroniser reset value is 1 (idle).
- Link FSM states: DOWN=0, QUAL=1, UP=2, HOLD=3. Reset state is DOWN.
  - DOWN: aligned=1 -> QUAL, qual counter cleared.
  - QUAL: aligned=0 -> DOWN. Counter reaching UP_QUAL_CYCLES-1 with aligned=1 -> UP.
  - UP: aligned=0 -> HOLD, hold counter cleared, link_drop_cnt+1 (saturates at 255, no wrap).
  - HOLD: aligned=1 -> UP, counter cleared, no further increment. Counter reaching DOWN_HOLD_CYCLES-1 with aligned=0 -> DOWN.
  - Simultaneous aligned change and counter terminal: aligned takes priority.
- Output path (all pin outputs registered):
  - UP: pins <= core values, 1-cycle latency.
  - HOLD: pins keep last registered value (frozen).
  - DOWN/QUAL: nl_pin_out=NL_SAFE, ll_pin_out=LL_SAFE, uart_tx_pin=1, uart_rts_pin=1 (deasserted).
- Core-side inputs (nl_gpio_in etc.) are always live, independent of FSM state.
- Reset values: pin outputs = safe values / 1 for UART; core-side outputs 0 except uart_rxd=uart_cts=1; link_state=0; link_drop_cnt=0.
- Reset asserted mid-operation: everything returns asynchronously to the reset values, and filter state is lost.
- Unused core bus bits above NL_PINS/LL_PINS are ignored on input and tied 0 on output.

Decomposition:
- Package ltpi_io_bridge_pkg: link_state_t enum (DOWN/QUAL/UP/HOLD) and the counter-width helper function ($clog2-based).
- Sub-module ltpi_io_filter: synchroniser plus FILTER_CYCLES glitch filter, parametrised width, instantiated for NL and LL pins.
- UART synchronisers and the FSM stay inline.

Test Plan (defaults unless stated):
- Reset then aligned=1 held: link_state 0->1, UP (2) after exactly 8 cycles in QUAL. Before UP nl_pin_out=0 and uart_tx_pin=1; after UP nl_pin_out tracks nl_gpio_out[7:0]=0xA5 one cycle later.
- nl_pin_in[3] pulses high for 3 cycles -> nl_gpio_in[3] stays 0. A 4-cycle pulse -> nl_gpio_in[3] rises 6 cycles after the pin edge.
- In UP, aligned drops for 5 cycles -> HOLD, outputs frozen at 0xA5, back to UP, link_drop_cnt=1. A drop of 16 cycles -> DOWN, nl_pin_out=NL_SAFE.
- 300 UP->HOLD->UP cycles -> link_drop_cnt saturates at 255.
- reset_in asserted asynchronously mid-UP (between clock edges) -> outputs immediately at reset values, link_state=0.
- NL_PINS=64, UART_CH=1, FILTER_CYCLES=1: pin changes reach core in 3 cycles; nl_gpio_in[1023:64]=0.
